// File: rtl/rgb_led_sequencer.sv
// Status LED driver: steady colour from base_rgb, prioritised blink sequences with one pending slot.
// Optional PWM dimming is built when RGB_PWM_EN is defined; otherwise brightness is ignored.
module rgb_led_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_BITS    = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          base_rgb,
  input  logic                flash_req,
  input  logic [2:0]          flash_rgb,
  input  logic [2:0]          flash_count,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                flash_busy,
  output logic                flash_done,
  output logic [2:0]          rgb_out
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PS_W-1:0]   presc_reg;
  logic [BT_W-1:0]   ticks_reg;
  logic [2:0]        remain_reg;
  logic [2:0]        color_reg;
  logic              pend_valid_reg;
  logic [2:0]        pend_rgb_reg;
  logic [2:0]        pend_count_reg;
  logic              done_reg;
  logic [2:0]        rgb_reg;

  logic              req_valid;
  logic              tick;
  logic              phase_end;
  logic              seq_end;
  logic              start_req;
  logic              start_pend;
  logic [2:0]        sel_rgb;
  logic [2:0]        rgb_next;

  assign req_valid = flash_req && (flash_count != 3'd0);
  assign tick      = (presc_reg == PS_W'(TICK_DIV - 1));
  assign phase_end = tick && (ticks_reg == BT_W'(BLINK_TICKS - 1));
  assign seq_end   = (state_reg == FLASH_OFF) && phase_end && (remain_reg == 3'd1);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state; a request on the completion edge outranks the pending slot
  always_comb begin
    state_next = state_reg;
    start_req  = 1'b0;
    start_pend = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          start_req  = 1'b1;
          state_next = FLASH_ON;
        end
      end
      FLASH_ON: begin
        if (phase_end) begin
          state_next = FLASH_OFF;
        end
      end
      FLASH_OFF: begin
        if (phase_end) begin
          if (remain_reg != 3'd1) begin
            state_next = FLASH_ON;
          end else if (req_valid) begin
            start_req  = 1'b1;
            state_next = FLASH_ON;
          end else if (pend_valid_reg) begin
            start_pend = 1'b1;
            state_next = FLASH_ON;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timing counters, captured sequence and pending slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg      <= '0;
      ticks_reg      <= '0;
      remain_reg     <= 3'd0;
      color_reg      <= 3'd0;
      pend_valid_reg <= 1'b0;
      pend_rgb_reg   <= 3'd0;
      pend_count_reg <= 3'd0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= seq_end;
      if (start_req) begin
        color_reg  <= flash_rgb;
        remain_reg <= flash_count;
        presc_reg  <= '0;
        ticks_reg  <= '0;
      end else if (start_pend) begin
        color_reg  <= pend_rgb_reg;
        remain_reg <= pend_count_reg;
        presc_reg  <= '0;
        ticks_reg  <= '0;
      end else if (state_reg != IDLE) begin
        presc_reg <= tick ? '0 : presc_reg + PS_W'(1);
        if (phase_end) begin
          ticks_reg <= '0;
        end else if (tick) begin
          ticks_reg <= ticks_reg + BT_W'(1);
        end
        if (state_reg == FLASH_OFF && phase_end) begin
          remain_reg <= remain_reg - 3'd1;
        end
      end

      if (start_pend) begin
        pend_valid_reg <= 1'b0;
      end else if (req_valid && state_reg != IDLE && !start_req) begin
        pend_valid_reg <= 1'b1;
        pend_rgb_reg   <= flash_rgb;
        pend_count_reg <= flash_count;
      end
    end
  end

  // Output colour selection
  always_comb begin
    sel_rgb = 3'b000;
    case (state_reg)
      IDLE:      sel_rgb = base_rgb;
      FLASH_ON:  sel_rgb = color_reg;
      FLASH_OFF: sel_rgb = 3'b000;
      default:   sel_rgb = 3'b000;
    endcase
  end

`ifdef RGB_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                pwm_on;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  // All-ones means fully on rather than on for 2^N-1 of 2^N cycles
  assign pwm_on = (brightness == '1) || (pwm_cnt_reg < brightness);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pwm
      assign rgb_next[gi] = sel_rgb[gi] & pwm_on;
    end
  endgenerate
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_direct
      assign rgb_next[gi] = sel_rgb[gi];
    end
  endgenerate
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_reg <= 3'b000;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign flash_busy = (state_reg != IDLE);
  assign flash_done = done_reg;
  assign rgb_out    = rgb_reg;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Self-checking bench for rgb_led_sequencer with TICK_DIV=2, BLINK_TICKS=3, PWM_BITS=4.
// Table vectors for steady/invalid cases, hand-written sequences for flash, pending, reset and PWM.
module tb_rgb_led_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] base_rgb = 3'b101;
  logic       flash_req = 1'b0;
  logic [2:0] flash_rgb = 3'b000;
  logic [2:0] flash_count = 3'd0;
  logic [3:0] brightness = 4'hF;
  logic       flash_busy;
  logic       flash_done;
  logic [2:0] rgb_out;

  int n_checks = 0;
  int n_fail = 0;

  rgb_led_sequencer #(
    .TICK_DIV(2),
    .BLINK_TICKS(3),
    .PWM_BITS(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .base_rgb(base_rgb),
    .flash_req(flash_req),
    .flash_rgb(flash_rgb),
    .flash_count(flash_count),
    .brightness(brightness),
    .flash_busy(flash_busy),
    .flash_done(flash_done),
    .rgb_out(rgb_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       req;
    logic [2:0] frgb;
    logic [2:0] fcnt;
    logic [2:0] base;
    logic [2:0] exp_rgb;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] er, input logic eb, input logic ed);
    chk({tag, " rgb_out"}, rgb_out, er);
    chk({tag, " flash_busy"}, {2'b00, flash_busy}, {2'b00, eb});
    chk({tag, " flash_done"}, {2'b00, flash_done}, {2'b00, ed});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [2:0] er;
    int         hi_cnt [3];

    vecs[0] = '{req: 1'b0, frgb: 3'b000, fcnt: 3'd0, base: 3'b101, exp_rgb: 3'b101, exp_busy: 1'b0};
    vecs[1] = '{req: 1'b0, frgb: 3'b000, fcnt: 3'd0, base: 3'b011, exp_rgb: 3'b011, exp_busy: 1'b0};
    vecs[2] = '{req: 1'b1, frgb: 3'b111, fcnt: 3'd0, base: 3'b011, exp_rgb: 3'b011, exp_busy: 1'b0};
    vecs[3] = '{req: 1'b0, frgb: 3'b000, fcnt: 3'd0, base: 3'b110, exp_rgb: 3'b110, exp_busy: 1'b0};
    vecs[4] = '{req: 1'b1, frgb: 3'b010, fcnt: 3'd0, base: 3'b101, exp_rgb: 3'b101, exp_busy: 1'b0};
    vecs[5] = '{req: 1'b0, frgb: 3'b000, fcnt: 3'd0, base: 3'b101, exp_rgb: 3'b101, exp_busy: 1'b0};

    // Reset and steady colour
    #1 reset_n = 1'b0;
    #1 check_all("reset_async", 3'b000, 1'b0, 1'b0);
    step();
    step();
    check_all("reset_held", 3'b000, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    check_all("reset_release", 3'b101, 1'b0, 1'b0);
    $display("reset: rgb_out=%b busy=%b", rgb_out, flash_busy);

    foreach (vecs[i]) begin
      flash_req   = vecs[i].req;
      flash_rgb   = vecs[i].frgb;
      flash_count = vecs[i].fcnt;
      base_rgb    = vecs[i].base;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_busy, 1'b0);
      $display("vec %0d: req=%b cnt=%0d base=%b -> rgb_out=%b busy=%b",
               i, vecs[i].req, vecs[i].fcnt, vecs[i].base, rgb_out, flash_busy);
    end
    flash_req = 1'b0;

    // Normal flash (100, 2) with an invalid request while busy
    flash_req = 1'b1; flash_rgb = 3'b100; flash_count = 3'd2;
    step();
    check_all("flash_start", 3'b101, 1'b1, 1'b0);
    flash_req = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      flash_req = (j == 3); flash_rgb = 3'b111; flash_count = 3'd0;
      step();
      if (j == 25) er = 3'b101;
      else er = (((j - 1) / 6) % 2 == 0) ? 3'b100 : 3'b000;
      check_all($sformatf("flash_j%0d", j), er, (j < 24), (j == 24));
    end
    flash_req = 1'b0;
    $display("normal flash: done, rgb_out=%b busy=%b", rgb_out, flash_busy);

    // Pending overwrite: 010 then 001 queued during a (100,1) flash
    flash_req = 1'b1; flash_rgb = 3'b100; flash_count = 3'd1;
    step();
    check_all("pend_start", 3'b101, 1'b1, 1'b0);
    flash_req = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      flash_req = 1'b0;
      if (j == 2) begin flash_req = 1'b1; flash_rgb = 3'b010; flash_count = 3'd1; end
      if (j == 4) begin flash_req = 1'b1; flash_rgb = 3'b001; flash_count = 3'd1; end
      step();
      if (j <= 6) er = 3'b100;
      else if (j <= 12) er = 3'b000;
      else if (j <= 18) er = 3'b001;
      else if (j <= 24) er = 3'b000;
      else er = 3'b101;
      check_all($sformatf("pend_j%0d", j), er, (j < 24), (j == 12 || j == 24));
    end
    flash_req = 1'b0;
    $display("pending overwrite: done, rgb_out=%b busy=%b", rgb_out, flash_busy);

    // Reset mid-flash with a pending entry
    flash_req = 1'b1; flash_rgb = 3'b010; flash_count = 3'd3;
    step();
    flash_req = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      flash_req = (j == 2); flash_rgb = 3'b001; flash_count = 3'd1;
      step();
    end
    flash_req = 1'b0;
    check_all("midrst_before", 3'b010, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1 check_all("midrst_async", 3'b000, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step();
      check_all($sformatf("postrst_j%0d", j), 3'b101, 1'b0, 1'b0);
    end
    $display("reset mid-flash: rgb_out=%b busy=%b", rgb_out, flash_busy);

    // Brightness handling
    base_rgb = 3'b111;
`ifdef RGB_PWM_EN
    brightness = 4'd4;
    step();
    for (int c = 0; c < 3; c++) hi_cnt[c] = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      for (int c = 0; c < 3; c++) if (rgb_out[c]) hi_cnt[c]++;
    end
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("pwm4_ch%0d_high", c), 3'(hi_cnt[c]), 3'd4);
    end
    brightness = 4'd0;
    step();
    for (int j = 0; j < 16; j++) begin
      step();
      chk($sformatf("pwm0_j%0d", j), rgb_out, 3'b000);
    end
    $display("pwm: brightness 4 high counts %0d/%0d/%0d", hi_cnt[0], hi_cnt[1], hi_cnt[2]);
`else
    for (int c = 0; c < 3; c++) hi_cnt[c] = 0;
    brightness = 4'd0;
    step();
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("nopwm_j%0d", j), rgb_out, 3'b111);
    end
    $display("no pwm: brightness 0 rgb_out=%b", rgb_out);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
